sd_block_responder: RTL and testbench

- Simulation and bench-side model of the HPS block-device end of the hps_io sd_* interface.
- Answers per-drive sd_rd/sd_wr requests with the sd_ack handshake.
- Streams 512-byte sectors into the core's sector buffer via sd_buff_addr/sd_buff_dout/sd_buff_wr, and captures sd_buff_din on writes.
- Backed by a flat byte-addressed image memory port.
- Lets the IIgs HDD and floppy requester logic run unmodified under Verilator and in benches.

---
 rtl/sd_resp_pkg.sv | 20 ++
 rtl/sd_block_responder_if.sv | 36 +++
 rtl/sd_resp_arbiter.sv | 22 ++
 rtl/sd_block_responder.sv | 186 ++++++++++++++++++
 tb/tb_sd_block_responder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and sector geometry for the sd_* block-device responder.
package sd_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_XFER,
    WR_XFER,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;

endpackage

// File: rtl/sd_block_responder_if.sv
// hps_io sd_* request/sector-buffer signals plus the flat image memory port.
interface sd_block_responder_if #(
  parameter int VDNUM  = 3,
  parameter int IMG_AW = 24
);
  logic [VDNUM*32-1:0]     sd_lba;
  logic [VDNUM-1:0]        sd_rd;
  logic [VDNUM-1:0]        sd_wr;
  logic [VDNUM-1:0]        sd_ack;
  logic [8:0]              sd_buff_addr;
  logic [7:0]              sd_buff_dout;
  logic [VDNUM*8-1:0]      sd_buff_din;
  logic                    sd_buff_wr;
  logic [VDNUM*IMG_AW-1:0] img_base;
  logic [VDNUM*IMG_AW-1:0] img_size;
  logic [IMG_AW-1:0]       img_addr;
  logic                    img_rd;
  logic [7:0]              img_q;
  logic                    img_we;
  logic [7:0]              img_d;
  logic                    busy;

  // Core and image memory side.
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_base, img_size, img_q,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  img_addr, img_rd, img_we, img_d, busy
  );

  // Responder side.
  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_base, img_size, img_q,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output img_addr, img_rd, img_we, img_d, busy
  );
endinterface

// File: rtl/sd_resp_arbiter.sv
// Lowest-index-wins picker over the per-channel request levels.
module sd_resp_arbiter #(
  parameter int VDNUM = 3,
  parameter int CH_W  = 2
) (
  input  logic [VDNUM-1:0] req,
  output logic             valid,
  output logic [CH_W-1:0]  ch
);

  always_comb begin
    valid = |req;
    ch    = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = VDNUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        ch = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/sd_block_responder.sv
// Block-device responder: serves one 512-byte sector per sd_rd/sd_wr request
// from a flat image memory, with the sd_ack handshake and sector-buffer strobes.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int VDNUM     = 3,
  parameter int IMG_AW    = 24,
  parameter int ACK_DELAY = 16
) (
  input logic clk_sys,
  input logic reset_n,
  sd_block_responder_if.slave bus
);

  localparam int CH_W  = (VDNUM > 1) ? $clog2(VDNUM) : 1;
  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  logic [31:0]       lba_arr  [VDNUM];
  logic [IMG_AW-1:0] base_arr [VDNUM];
  logic [IMG_AW-1:0] size_arr [VDNUM];
  logic [7:0]        din_arr  [VDNUM];
  logic [VDNUM-1:0]  req;

  generate
    for (genvar gi = 0; gi < VDNUM; gi++) begin : g_ch
      assign lba_arr[gi]  = bus.sd_lba[32*gi +: 32];
      assign base_arr[gi] = bus.img_base[IMG_AW*gi +: IMG_AW];
      assign size_arr[gi] = bus.img_size[IMG_AW*gi +: IMG_AW];
      assign din_arr[gi]  = bus.sd_buff_din[8*gi +: 8];
      assign req[gi]      = bus.sd_rd[gi] | bus.sd_wr[gi];
    end
  endgenerate

  logic            req_valid;
  logic [CH_W-1:0] req_ch;

  sd_resp_arbiter #(
    .VDNUM (VDNUM),
    .CH_W  (CH_W)
  ) u_arbiter (
    .req   (req),
    .valid (req_valid),
    .ch    (req_ch)
  );

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [9:0]        idx_reg, idx_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  op_t               op_reg, op_next;
  logic              in_range_reg, in_range_next;
  logic [IMG_AW-1:0] sect_addr_reg, sect_addr_next;
  logic [VDNUM-1:0]  ack_reg, ack_next;

  logic [8:0]        buff_addr;
  logic [7:0]        buff_dout;
  logic              buff_wr;
  logic [IMG_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_we;
  logic [7:0]        mem_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      ch_reg        <= '0;
      op_reg        <= OP_RD;
      in_range_reg  <= 1'b0;
      sect_addr_reg <= '0;
      ack_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      ch_reg        <= ch_next;
      op_reg        <= op_next;
      in_range_reg  <= in_range_next;
      sect_addr_reg <= sect_addr_next;
      ack_reg       <= ack_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    ch_next        = ch_reg;
    op_next        = op_reg;
    in_range_next  = in_range_reg;
    sect_addr_next = sect_addr_reg;
    ack_next       = ack_reg;
    buff_addr      = '0;
    buff_dout      = '0;
    buff_wr        = 1'b0;
    mem_addr       = '0;
    mem_rd         = 1'b0;
    mem_we         = 1'b0;
    mem_d          = '0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          ch_next        = req_ch;
          op_next        = bus.sd_rd[req_ch] ? OP_RD : OP_WR;
          // Last byte of the sector must sit below the image size; size 0 never passes.
          in_range_next  = {lba_arr[req_ch], {SECTOR_SHIFT{1'b1}}} < 41'(size_arr[req_ch]);
          sect_addr_next = base_arr[req_ch]
                         + IMG_AW'({lba_arr[req_ch], {SECTOR_SHIFT{1'b0}}});
          cnt_next       = CNT_W'(ACK_DELAY - 1);
          state_next     = WAIT;
        end
      end

      WAIT: begin
        if (cnt_reg == '0) begin
          ack_next         = '0;
          ack_next[ch_reg] = 1'b1;
          idx_next         = '0;
          state_next       = (op_reg == OP_RD) ? RD_XFER : WR_XFER;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      RD_XFER: begin
        // Image read issued at idx lands in the buffer one cycle later as idx-1.
        if (idx_reg < 10'(SECTOR_BYTES)) begin
          mem_rd = in_range_reg;
          if (in_range_reg) begin
            mem_addr = sect_addr_reg + IMG_AW'(idx_reg);
          end
        end
        if (idx_reg != '0) begin
          buff_wr   = 1'b1;
          buff_addr = 9'(idx_reg - 10'd1);
          buff_dout = in_range_reg ? bus.img_q : 8'h00;
        end
        if (idx_reg == 10'(SECTOR_BYTES)) begin
          ack_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 10'd1;
        end
      end

      WR_XFER: begin
        if (idx_reg < 10'(SECTOR_BYTES)) begin
          buff_addr = idx_reg[8:0];
        end
        // Core buffer answers one cycle after the address, so write byte idx-1 now.
        if (idx_reg != '0 && in_range_reg) begin
          mem_we   = 1'b1;
          mem_addr = sect_addr_reg + IMG_AW'(idx_reg - 10'd1);
          mem_d    = din_arr[ch_reg];
        end
        if (idx_reg == 10'(SECTOR_BYTES)) begin
          ack_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 10'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.sd_ack       = ack_reg;
  assign bus.sd_buff_addr = buff_addr;
  assign bus.sd_buff_dout = buff_dout;
  assign bus.sd_buff_wr   = buff_wr;
  assign bus.img_addr     = mem_addr;
  assign bus.img_rd       = mem_rd;
  assign bus.img_we       = mem_we;
  assign bus.img_d        = mem_d;
  assign bus.busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized bench for sd_block_responder against a flat-image sector model.
module tb_sd_block_responder;

  localparam int VDNUM     = 3;
  localparam int IMG_AW    = 24;
  localparam int ACK_DELAY = 16;
  localparam int MEM_SZ    = 1 << 20;

  logic clk_sys  = 1'b0;
  logic reset_n  = 1'b0;
  logic fill_req = 1'b0;

  always #5 clk_sys = ~clk_sys;

  sd_block_responder_if #(.VDNUM(VDNUM), .IMG_AW(IMG_AW)) bus ();

  sd_block_responder #(
    .VDNUM     (VDNUM),
    .IMG_AW    (IMG_AW),
    .ACK_DELAY (ACK_DELAY)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_img [MEM_SZ];
  logic [7:0] wr_seed [VDNUM];
  longint     base_m  [VDNUM];
  longint     size_m  [VDNUM];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] first_b, last_b;

  // Image memory: one-cycle read latency, write on strobe.
  always @(posedge clk_sys) begin
    if (fill_req) begin
      for (int a = 0; a < MEM_SZ; a++) mem[a] <= a[7:0] ^ a[15:8];
    end else begin
      if (bus.img_we) mem[bus.img_addr[19:0]] <= bus.img_d;
      if (bus.img_rd) bus.img_q <= mem[bus.img_addr[19:0]];
    end
  end

  // Core sector buffer: returns addr+seed for each lane one cycle after the address.
  always @(posedge clk_sys) begin
    for (int i = 0; i < VDNUM; i++)
      bus.sd_buff_din[8*i +: 8] <= bus.sd_buff_addr[7:0] + wr_seed[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr,
                bus.img_addr, bus.img_rd, bus.img_we, bus.img_d, bus.busy});
  endfunction

  function automatic int region_diff(input longint start);
    int n = 0;
    for (int k = 0; k < 512; k++) begin
      int a = int'((start + k) & (MEM_SZ - 1));
      if (mem[a] !== ref_img[a]) n++;
    end
    return n;
  endfunction

  task automatic set_img(input int ch, input longint base, input longint size);
    base_m[ch] = base;
    size_m[ch] = size;
    bus.img_base[IMG_AW*ch +: IMG_AW] = IMG_AW'(base);
    bus.img_size[IMG_AW*ch +: IMG_AW] = IMG_AW'(size);
  endtask

  // One request on one channel; called and returns on a falling clock edge.
  task automatic run_xfer(input int ch, input bit rd, input bit wr,
                          input logic [31:0] lba, input bit keep);
    longint start = base_m[ch] + longint'(lba) * 512;
    bit inr   = (longint'(lba) * 512 + 511) < size_m[ch];
    bit is_rd = rd;
    int cyc = 0, acc = -1, ackc = -1, fall = -1, last_s = -1;
    int nstrb = 0, nrd = 0, nwe = 0, bad_ord = 0, derr = 0, ack_bad = 0;
    logic [7:0] exp;
    bus.sd_lba[32*ch +: 32] = lba;
    bus.sd_rd[ch] = rd;
    bus.sd_wr[ch] = wr;
    while (fall < 0 && cyc < 3000) begin
      @(negedge clk_sys);
      if (acc < 0 && bus.busy) acc = cyc;
      if (acc >= 0 && !bus.busy) fall = cyc;
      if (bus.sd_ack != '0 && bus.sd_ack != VDNUM'(1 << ch)) ack_bad++;
      if (bus.sd_ack[ch] && ackc < 0) begin
        ackc = cyc;
        if (!keep) begin
          bus.sd_rd[ch] = 1'b0;
          bus.sd_wr[ch] = 1'b0;
        end
      end
      if (bus.sd_buff_wr) begin
        exp = (is_rd && inr) ? ref_img[int'((start + nstrb) & (MEM_SZ - 1))] : 8'h00;
        if (bus.sd_buff_addr != 9'(nstrb)) bad_ord++;
        if (bus.sd_buff_dout !== exp) derr++;
        if (nstrb == 0) first_b = bus.sd_buff_dout;
        if (nstrb == 511) last_b = bus.sd_buff_dout;
        nstrb++;
        last_s = cyc;
      end
      if (bus.img_rd) nrd++;
      if (bus.img_we) nwe++;
      cyc++;
    end
    if (!keep) begin
      bus.sd_rd[ch] = 1'b0;
      bus.sd_wr[ch] = 1'b0;
    end
    if (!is_rd && inr)
      for (int k = 0; k < 512; k++)
        ref_img[int'((start + k) & (MEM_SZ - 1))] = 8'(k) + wr_seed[ch];
    $display("xfer ch=%0d %s lba=%0d in_range=%0d ack_dly=%0d strobes=%0d rd=%0d we=%0d",
             ch, is_rd ? "RD" : "WR", lba, inr, ackc - acc, nstrb, nrd, nwe);
    check("done", 64'(fall >= 0), 64'd1);
    check("ack_dly", 64'(ackc - acc), 64'(ACK_DELAY));
    check("ack_onehot", 64'(ack_bad), 64'd0);
    check("strobes", 64'(nstrb), is_rd ? 64'd512 : 64'd0);
    check("img_rd_cnt", 64'(nrd), (is_rd && inr) ? 64'd512 : 64'd0);
    check("img_we_cnt", 64'(nwe), (!is_rd && inr) ? 64'd512 : 64'd0);
    if (is_rd) begin
      check("rd_order", 64'(bad_ord), 64'd0);
      check("rd_data", 64'(derr), 64'd0);
      check("rd_tail", 64'(fall - last_s), 64'd2);
    end else begin
      check("wr_image", 64'(region_diff(start)), 64'd0);
    end
  endtask

  initial begin
    int found, cyc, nd;
    bus.sd_lba   = '0;
    bus.sd_rd    = '0;
    bus.sd_wr    = '0;
    bus.img_base = '0;
    bus.img_size = '0;
    for (int i = 0; i < VDNUM; i++) wr_seed[i] = 8'(i * 16 + 1);
    for (int a = 0; a < MEM_SZ; a++) ref_img[a] = a[7:0] ^ a[15:8];
    set_img(0, 0, MEM_SZ);
    set_img(1, 'h10000, 'h20000);
    set_img(2, 'h40000, 'h8000);
    fill_req = 1'b1;
    @(posedge clk_sys);
    #1 fill_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("idle_outs", outs(), 64'd0);

    // In-range read, channel 0, lba 2.
    run_xfer(0, 1'b1, 1'b0, 32'd2, 1'b0);
    check("rd_first", 64'(first_b), 64'h04);
    check("rd_last", 64'(last_b), 64'(ref_img[1535]));

    // Write on channel 1, din = addr+1.
    wr_seed[1] = 8'd1;
    run_xfer(1, 1'b0, 1'b1, 32'd0, 1'b0);
    check("wr_first", 64'(mem['h10000]), 64'h01);
    check("wr_last", 64'(mem['h101FF]), 64'h00);

    // Out-of-range read and write.
    set_img(0, 0, 1024);
    run_xfer(0, 1'b1, 1'b0, 32'd2, 1'b0);
    check("oor_last", 64'(last_b), 64'h00);
    run_xfer(0, 1'b0, 1'b1, 32'd2, 1'b0);
    set_img(0, 0, MEM_SZ);

    // Simultaneous: write on 0, read on 2.
    begin
      int first_ack = -1, overlap = 0, gap = 0, phase = 0, done = 0;
      int nstrb = 0, nwe = 0, derr = 0;
      for (int k = 0; k < 512; k++) ref_img[3*512 + k] = 8'(k) + wr_seed[0];
      bus.sd_lba[31:0]  = 32'd3;
      bus.sd_lba[95:64] = 32'd7;
      bus.sd_wr[0] = 1'b1;
      bus.sd_rd[2] = 1'b1;
      cyc = 0;
      while (!done && cyc < 4000) begin
        @(negedge clk_sys);
        if (first_ack < 0 && bus.sd_ack != '0)
          first_ack = bus.sd_ack[0] ? 0 : (bus.sd_ack[1] ? 1 : 2);
        if (bus.sd_ack[0] && bus.sd_ack[2]) overlap++;
        if (bus.sd_ack[0]) bus.sd_wr[0] = 1'b0;
        if (bus.sd_ack[2]) bus.sd_rd[2] = 1'b0;
        case (phase)
          0: if (bus.busy) phase = 1;
          1: if (!bus.busy) begin phase = 2; gap = 1; end
          2: if (bus.busy) phase = 3; else gap++;
          default: if (!bus.busy) done = 1;
        endcase
        if (bus.sd_buff_wr) begin
          if (bus.sd_buff_dout !== ref_img['h40000 + 7*512 + int'(bus.sd_buff_addr)]) derr++;
          nstrb++;
        end
        if (bus.img_we) nwe++;
        cyc++;
      end
      $display("xfer simultaneous first_ack=%0d gap=%0d strobes=%0d we=%0d", first_ack, gap, nstrb, nwe);
      check("sim_done", 64'(done), 64'd1);
      check("sim_first", 64'(first_ack), 64'd0);
      check("sim_overlap", 64'(overlap), 64'd0);
      check("sim_gap", 64'(gap), 64'd1);
      check("sim_strobes", 64'(nstrb), 64'd512);
      check("sim_rdata", 64'(derr), 64'd0);
      check("sim_we", 64'(nwe), 64'd512);
      check("sim_wimage", 64'(region_diff(3*512)), 64'd0);
    end

    // Reset in the middle of a read, request held through reset.
    bus.sd_lba[31:0] = 32'd5;
    bus.sd_rd[0] = 1'b1;
    found = 0;
    cyc = 0;
    while (!found && cyc < 2000) begin
      @(negedge clk_sys);
      if (bus.sd_buff_wr && bus.sd_buff_addr == 9'd100) found = 1;
      cyc++;
    end
    check("rst_strobe100", 64'(found), 64'd1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("rst_mid_outs", outs(), 64'd0);
    reset_n = 1'b1;
    run_xfer(0, 1'b1, 1'b0, 32'd5, 1'b0);
    check("rst_first", 64'(first_b), 64'(ref_img[5*512]));

    // Both levels on channel 1: a read, then re-accepted as a read.
    run_xfer(1, 1'b1, 1'b1, 32'd9, 1'b1);
    run_xfer(1, 1'b1, 1'b1, 32'd9, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      int ch = int'($urandom_range(0, VDNUM - 1));
      int op = int'($urandom_range(0, 2));
      int maxl = int'(size_m[ch] / 512) + 4;
      logic [31:0] lba = 32'($urandom_range(0, maxl));
      if (i == 10) set_img(2, 'h40000, 0);
      for (int j = 0; j < VDNUM; j++) wr_seed[j] = 8'($urandom);
      run_xfer(ch, op != 1, op != 0, lba, 1'b0);
    end

    nd = 0;
    for (int a = 0; a < MEM_SZ; a++) if (mem[a] !== ref_img[a]) nd++;
    check("img_final", 64'(nd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
